// File: rtl/nh_lcd_data_reader.sv
// nh_lcd_data_reader: 8080-bus frame readback into a ping-pong FIFO of RGB words.
// Options: SIMULATION (4-word buffers), NH_LCD_DUMMY_READ_EN (discard first byte).
`ifndef CMD_START_MEM_READ
`define CMD_START_MEM_READ 8'h2E
`endif

module nh_lcd_data_reader #(
    parameter int BUFFER_SIZE = 12
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] debug,
    input  logic        i_enable,
    input  logic [31:0] i_num_pixels,
    output logic        o_finished,
    output logic        o_fifo_rdy,
    input  logic        i_fifo_act,
    input  logic        i_fifo_stb,
    output logic [23:0] o_fifo_size,
    output logic [31:0] o_fifo_data,
    output logic        o_cmd_mode,
    output logic [7:0]  o_data_out,
    input  logic [7:0]  i_data_in,
    output logic        o_write,
    output logic        o_read,
    output logic        o_data_out_en
);

`ifdef SIMULATION
    localparam int AW = 2;
`else
    localparam int AW = BUFFER_SIZE;
`endif
    localparam int DEPTH = 1 << AW;
    localparam logic [23:0] WR_SIZE = 24'(DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        WRITE_CMD,
        CMD_DELAY,
        DUMMY_READ,
        DUMMY_DELAY,
        GET_BUFFER,
        READ_RED_START,
        READ_RED,
        READ_GREEN_START,
        READ_GREEN,
        READ_BLUE_START,
        READ_BLUE,
        PUSH,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0] total;
    logic [31:0] pix_cnt;
    logic [23:0] word_cnt;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        abort;
    logic        fin_nx;

    logic        wr_take;
    logic        wr_take_sel;
    logic        wr_stb;
    logic        wr_rel;
    logic [23:0] wr_rel_cnt;
    logic        wr_held;
    logic        wr_sel;
    logic [1:0]  wr_ready;

    logic [1:0]  full;
    logic [23:0] buf_cnt [2];
    logic        oldest;
    logic        rd_take;
    logic        rd_held;
    logic        rd_sel;
    logic [AW-1:0] rd_ptr;

    logic [31:0] mem [0:2*DEPTH-1];
    logic [7:0]  bus_byte;

    assign abort = !i_enable && (state != IDLE) && (state != DONE);

    // A buffer is writable when it holds no unread data and is not ours already.
    assign wr_ready[0] = !full[0] && !(wr_held && !wr_sel);
    assign wr_ready[1] = !full[1] && !(wr_held && wr_sel);

    always_comb begin
        state_nx    = state;
        fin_nx      = 1'b0;
        wr_take     = 1'b0;
        wr_take_sel = 1'b0;
        wr_stb      = 1'b0;
        wr_rel      = 1'b0;
        wr_rel_cnt  = word_cnt;
        if (abort) begin
            state_nx = IDLE;
            wr_rel   = wr_held;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_enable) begin
                        if (i_num_pixels == 32'd0) begin
                            fin_nx   = 1'b1;
                            state_nx = DONE;
                        end else begin
                            state_nx = WRITE_CMD;
                        end
                    end
                end
                WRITE_CMD: state_nx = CMD_DELAY;
                CMD_DELAY: begin
`ifdef NH_LCD_DUMMY_READ_EN
                    state_nx = DUMMY_READ;
`else
                    state_nx = GET_BUFFER;
`endif
                end
                DUMMY_READ:  state_nx = DUMMY_DELAY;
                DUMMY_DELAY: state_nx = GET_BUFFER;
                GET_BUFFER: begin
                    if (wr_held) begin
                        state_nx = READ_RED_START;
                    end else if (|wr_ready) begin
                        wr_take     = 1'b1;
                        wr_take_sel = !wr_ready[0];
                        state_nx    = READ_RED_START;
                    end
                end
                READ_RED_START:   state_nx = READ_RED;
                READ_RED:         state_nx = READ_GREEN_START;
                READ_GREEN_START: state_nx = READ_GREEN;
                READ_GREEN:       state_nx = READ_BLUE_START;
                READ_BLUE_START:  state_nx = READ_BLUE;
                READ_BLUE:        state_nx = PUSH;
                PUSH: begin
                    wr_stb     = 1'b1;
                    wr_rel_cnt = word_cnt + 24'd1;
                    if (pix_cnt + 32'd1 == total) begin
                        wr_rel   = 1'b1;
                        fin_nx   = 1'b1;
                        state_nx = DONE;
                    end else if (word_cnt + 24'd1 == WR_SIZE) begin
                        wr_rel   = 1'b1;
                        state_nx = GET_BUFFER;
                    end else begin
                        state_nx = READ_RED_START;
                    end
                end
                DONE: begin
                    if (!i_enable) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            total         <= 32'd0;
            pix_cnt       <= 32'd0;
            word_cnt      <= 24'd0;
            red           <= 8'd0;
            green         <= 8'd0;
            blue          <= 8'd0;
            o_cmd_mode    <= 1'b1;
            o_write       <= 1'b0;
            o_read        <= 1'b0;
            o_data_out    <= 8'd0;
            o_data_out_en <= 1'b1;
            o_finished    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && i_enable) begin
                total   <= i_num_pixels;
                pix_cnt <= 32'd0;
            end
            if (wr_take) word_cnt <= 24'd0;
            if (wr_stb) begin
                word_cnt <= word_cnt + 24'd1;
                pix_cnt  <= pix_cnt + 32'd1;
            end
            if (state == READ_RED)   red   <= i_data_in;
            if (state == READ_GREEN) green <= i_data_in;
            if (state == READ_BLUE)  blue  <= i_data_in;
            o_cmd_mode    <= (state_nx != WRITE_CMD);
            o_write       <= (state_nx == WRITE_CMD);
            o_read        <= state_nx inside {DUMMY_READ, READ_RED_START,
                                              READ_GREEN_START, READ_BLUE_START};
            o_data_out    <= (state_nx == WRITE_CMD) ? `CMD_START_MEM_READ : 8'd0;
            o_data_out_en <= state_nx inside {IDLE, WRITE_CMD, DONE};
            o_finished    <= fin_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_stb) mem[{wr_sel, word_cnt[AW-1:0]}] <= {8'h00, red, green, blue};
    end

    assign rd_take     = i_fifo_act && !rd_held && full[oldest];
    assign o_fifo_rdy  = !rd_held && full[oldest];
    assign o_fifo_size = buf_cnt[rd_sel];
    assign o_fifo_data = mem[{rd_sel, rd_ptr}];

    // oldest always names the earliest filled buffer awaiting the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_held    <= 1'b0;
            wr_sel     <= 1'b0;
            full       <= 2'b00;
            oldest     <= 1'b0;
            rd_held    <= 1'b0;
            rd_sel     <= 1'b0;
            rd_ptr     <= '0;
            buf_cnt[0] <= 24'd0;
            buf_cnt[1] <= 24'd0;
        end else begin
            if (wr_take) begin
                wr_held <= 1'b1;
                wr_sel  <= wr_take_sel;
            end
            if (wr_rel) begin
                wr_held         <= 1'b0;
                buf_cnt[wr_sel] <= wr_rel_cnt;
                if (wr_rel_cnt != 24'd0) begin
                    full[wr_sel] <= 1'b1;
                    if (!full[~wr_sel]) oldest <= wr_sel;
                end
            end
            if (rd_take) begin
                rd_held <= 1'b1;
                rd_sel  <= oldest;
                rd_ptr  <= '0;
            end else if (rd_held) begin
                if (!i_fifo_act) begin
                    rd_held      <= 1'b0;
                    full[rd_sel] <= 1'b0;
                    oldest       <= ~rd_sel;
                end else if (i_fifo_stb) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    assign bus_byte = o_data_out_en ? o_data_out : i_data_in;
    assign debug = {15'd0, o_data_out_en, 4'(state), bus_byte,
                    o_read, o_write, o_cmd_mode, i_enable};

endmodule
